tmds_video_decoder: RTL and testbench

- Consumes the 30-bit per-pixel-clock TMDS symbol stream produced by the receive/CDC pass-through stage: {red, green, blue} 10-bit symbols with a valid strobe.
- Decodes DVI video: 8b/10b data symbols become a 24-bit pixel, and control tokens become hsync/vsync.
- Marks start-of-frame and end-of-line, and measures active resolution.
- Feeds the capture/frame-buffer logic.
- Single clock domain (the pass-through output clock).

---
 rtl/tmds_video_decoder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_tmds_video_decoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_video_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_video_decoder
//  Description : DVI TMDS symbol decoder. Turns the per-pixel-clock
//                {red, green, blue} 10-bit symbol triplet into a 24-bit
//                pixel with de/hsync/vsync, marks start-of-frame and
//                end-of-line, and measures the active resolution with a
//                frame-stability lock indicator.
//  Ports       : clk, rst        - pixel clock, synchronous active-high reset
//                valid_in        - input beat strobe (gaps allowed)
//                data_in[29:0]   - {ch2/red, ch1/green, ch0/blue} symbols,
//                                  bit 0 of each symbol is the first serial bit
//                pixel_valid     - output beat strobe
//                pixel[23:0]     - {R,G,B}, zero during blanking
//                de/hsync/vsync  - active video and ch0 control bits
//                sof/eol         - first pixel of frame / last pixel of line
//                h_active/v_active, timing_locked - measured resolution
//                sym_err         - channels disagree on control vs data
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_video_decoder #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [29:0]      data_in,
    output logic             pixel_valid,
    output logic [23:0]      pixel,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             sof,
    output logic             eol,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic             timing_locked,
    output logic             sym_err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [9:0]       c_TOK_00  = 10'b1101010100;
    localparam logic [9:0]       c_TOK_01  = 10'b0010101011;
    localparam logic [9:0]       c_TOK_10  = 10'b0101010100;
    localparam logic [9:0]       c_TOK_11  = 10'b1010101011;
    localparam logic [3:0]       c_LOCK    = 4'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Symbol helpers
    // ------------------------------------------------------------------
    // Returns {is_control, c1, c0}.
    function automatic logic [2:0] f_ctl(input logic [9:0] q);
        logic [2:0] r;
        case (q)
            c_TOK_00: r = 3'b100;
            c_TOK_01: r = 3'b101;
            c_TOK_10: r = 3'b110;
            c_TOK_11: r = 3'b111;
            default:  r = 3'b000;
        endcase
        return r;
    endfunction

    // 10b -> 8b data decode: undo the optional inversion, then undo the
    // XOR/XNOR transition chain selected by q[8].
    function automatic logic [7:0] f_dec(input logic [9:0] q);
        logic [7:0] v;
        logic [7:0] d;
        v    = q[9] ? ~q[7:0] : q[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : v + c_CNT_ONE;
    endfunction

    // ------------------------------------------------------------------
    // Input beat decode
    // ------------------------------------------------------------------
    logic [2:0]  w_ctl0;
    logic [2:0]  w_ctl1;
    logic [2:0]  w_ctl2;
    logic        w_in_de;
    logic        w_in_err;
    logic [23:0] w_in_pix;
    logic        w_in_hs;
    logic        w_in_vs;
    logic        w_vs_edge;
    logic        w_in_sof;

    // Lookahead stage: holds beat k until beat k+1 arrives. hsync/vsync
    // of this stage double as the running sync state.
    logic        r_la_vld;
    logic [23:0] r_la_pix;
    logic        r_la_de;
    logic        r_la_hs;
    logic        r_la_vs;
    logic        r_la_sof;
    logic        r_la_err;
    logic        r_armed;

    assign w_ctl0    = f_ctl(data_in[9:0]);
    assign w_ctl1    = f_ctl(data_in[19:10]);
    assign w_ctl2    = f_ctl(data_in[29:20]);
    assign w_in_de   = ~w_ctl0[2];
    assign w_in_err  = (w_ctl0[2] != w_ctl1[2]) || (w_ctl0[2] != w_ctl2[2]);
    assign w_in_pix  = w_in_de ? {f_dec(data_in[29:20]), f_dec(data_in[19:10]),
                                  f_dec(data_in[9:0])} : 24'd0;
    assign w_in_hs   = w_ctl0[2] ? w_ctl0[0] : r_la_hs;
    assign w_in_vs   = w_ctl0[2] ? w_ctl0[1] : r_la_vs;
    // A vsync change of either polarity arms sof for the next de beat.
    assign w_vs_edge = w_ctl0[2] && (w_ctl0[1] != r_la_vs);
    assign w_in_sof  = w_in_de && r_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_la_vld <= 1'b0;
            r_la_pix <= 24'd0;
            r_la_de  <= 1'b0;
            r_la_hs  <= 1'b0;
            r_la_vs  <= 1'b0;
            r_la_sof <= 1'b0;
            r_la_err <= 1'b0;
            r_armed  <= 1'b0;
        end else if (valid_in) begin
            r_la_vld <= 1'b1;
            r_la_pix <= w_in_pix;
            r_la_de  <= w_in_de;
            r_la_hs  <= w_in_hs;
            r_la_vs  <= w_in_vs;
            r_la_sof <= w_in_sof;
            r_la_err <= w_in_err;
            r_armed  <= w_vs_edge | (r_armed & ~w_in_sof);
        end
    end

    // ------------------------------------------------------------------
    // Output stage: beat k is emitted when beat k+1 is accepted, which
    // is what gives eol its one-beat lookahead.
    // ------------------------------------------------------------------
    logic w_emit;
    logic w_eol;

    assign w_emit = valid_in && r_la_vld;
    assign w_eol  = r_la_de && !w_in_de;

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            pixel       <= 24'd0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            sym_err     <= 1'b0;
        end else begin
            pixel_valid <= w_emit;
            if (w_emit) begin
                pixel   <= r_la_pix;
                de      <= r_la_de;
                hsync   <= r_la_hs;
                vsync   <= r_la_vs;
                sof     <= r_la_sof;
                eol     <= w_eol;
                sym_err <= r_la_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line / frame measurement
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_lcnt;
    logic [CNT_W-1:0] r_first_len;
    logic             r_frame_bad;
    logic             r_in_frame;
    logic [CNT_W-1:0] r_prev_len;
    logic [CNT_W-1:0] r_prev_lines;
    logic [3:0]       r_stable;

    logic [CNT_W-1:0] w_run_len;
    logic [CNT_W-1:0] w_lcnt_base;
    logic [CNT_W-1:0] w_first_base;
    logic             w_bad_base;
    logic             w_good;
    logic             w_match;
    logic [3:0]       w_stable_inc;
    logic [3:0]       w_stable_nxt;

    always_comb begin
        w_run_len    = '0;
        w_lcnt_base  = r_lcnt;
        w_first_base = r_first_len;
        w_bad_base   = r_frame_bad;
        if (r_la_de) begin
            w_run_len = f_sat_inc(r_hcnt);
        end
        // A sof beat opens a fresh frame before its own eol is applied,
        // so a one-pixel first line lands in the new frame.
        if (r_la_sof) begin
            w_lcnt_base  = '0;
            w_first_base = '0;
            w_bad_base   = 1'b0;
        end
        w_good       = !r_frame_bad && (r_first_len != '0) && (r_lcnt != '0);
        w_match      = w_good && (r_first_len == r_prev_len) &&
                       (r_lcnt == r_prev_lines);
        w_stable_inc = (r_stable >= c_LOCK) ? c_LOCK : r_stable + 4'd1;
        w_stable_nxt = w_match ? w_stable_inc : {3'b000, w_good};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt        <= '0;
            r_lcnt        <= '0;
            r_first_len   <= '0;
            r_frame_bad   <= 1'b0;
            r_in_frame    <= 1'b0;
            r_prev_len    <= '0;
            r_prev_lines  <= '0;
            r_stable      <= 4'd0;
            h_active      <= '0;
            v_active      <= '0;
            timing_locked <= 1'b0;
        end else if (w_emit) begin
            r_hcnt <= w_run_len;
            r_lcnt <= w_eol ? f_sat_inc(w_lcnt_base) : w_lcnt_base;
            r_first_len <= (w_eol && (w_lcnt_base == '0)) ? w_run_len : w_first_base;
            r_frame_bad <= w_bad_base |
                           (w_eol && (w_lcnt_base != '0) && (w_run_len != w_first_base));
            if (r_la_sof) begin
                r_in_frame <= 1'b1;
                // The very first sof after reset has no completed frame behind it.
                if (r_in_frame) begin
                    r_stable      <= w_stable_nxt;
                    timing_locked <= (w_stable_nxt >= c_LOCK);
                    if (w_good) begin
                        h_active     <= r_first_len;
                        v_active     <= r_lcnt;
                        r_prev_len   <= r_first_len;
                        r_prev_lines <= r_lcnt;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmds_video_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmds_video_decoder
//  Description : Directed self-checking bench for tmds_video_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_video_decoder;

    localparam logic [9:0] c_T00 = 10'b1101010100;
    localparam logic [9:0] c_T01 = 10'b0010101011;
    localparam logic [9:0] c_T10 = 10'b0101010100;
    localparam logic [9:0] c_T11 = 10'b1010101011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [29:0] data_in;
    logic        pixel_valid;
    logic [23:0] pixel;
    logic        de, hsync, vsync, sof, eol, timing_locked, sym_err;
    logic [11:0] h_active, v_active;

    int checks   = 0;
    int failures = 0;
    int n_in     = 0;
    int n_pv     = 0;
    int pv0;
    bit gap_mode = 1'b0;
    logic frame_vs;

    // bench model state
    logic        m_hs, m_vs, m_armed, p_have;
    logic [23:0] p_pix;
    logic        p_de, p_hs, p_vs, p_sof, p_err;

    tmds_video_decoder #(.CNT_W(12), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
        .pixel_valid(pixel_valid), .pixel(pixel), .de(de), .hsync(hsync),
        .vsync(vsync), .sof(sof), .eol(eol), .h_active(h_active),
        .v_active(v_active), .timing_locked(timing_locked), .sym_err(sym_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pixel_valid) n_pv <= n_pv + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {is_control, c1, c0}
    function automatic logic [2:0] tok_dec(input logic [9:0] q);
        case (q)
            c_T00:   return 3'b100;
            c_T01:   return 3'b101;
            c_T10:   return 3'b110;
            c_T11:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [9:0] tokv(input logic [1:0] c);
        case (c)
            2'b00:   return c_T00;
            2'b01:   return c_T01;
            2'b10:   return c_T10;
            default: return c_T11;
        endcase
    endfunction

    // Forward transition-minimising encoder; the decoder reference searches it.
    function automatic logic [7:0] enc_qm(input logic [7:0] d, input logic x);
        logic [7:0] qm;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = x ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
        return qm;
    endfunction

    function automatic logic [7:0] ref_dec(input logic [9:0] q);
        logic [7:0] target;
        target = q[9] ? ~q[7:0] : q[7:0];
        for (int v = 0; v < 256; v++) begin
            if (enc_qm(8'(v), q[8]) == target) return 8'(v);
        end
        return 8'h00;
    endfunction

    task automatic model_clear();
        m_hs = 0; m_vs = 0; m_armed = 0; p_have = 0; frame_vs = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        chk("reset_outputs",
            {pixel_valid, pixel, de, hsync, vsync, sof, eol, sym_err,
             h_active, v_active, timing_locked}, 64'd0);
    endtask

    task automatic beat(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        logic [2:0]  t0, t1, t2;
        logic        c_de, c_sof, c_err;
        logic [23:0] c_pix;
        t0 = tok_dec(b); t1 = tok_dec(g); t2 = tok_dec(r);
        c_de  = !t0[2];
        c_err = (t0[2] != t1[2]) || (t0[2] != t2[2]);
        c_pix = c_de ? {ref_dec(r), ref_dec(g), ref_dec(b)} : 24'd0;
        if (t0[2]) begin
            if (t0[1] != m_vs) m_armed = 1'b1;
            m_hs = t0[0];
            m_vs = t0[1];
        end
        c_sof = c_de & m_armed;
        if (c_sof) m_armed = 1'b0;
        valid_in = 1'b1; data_in = {r, g, b}; n_in++;
        @(posedge clk); #1;
        valid_in = 1'b0;
        if (p_have)
            chk("beat", {pixel_valid, pixel, de, hsync, vsync, sof, eol, sym_err},
                {1'b1, p_pix, p_de, p_hs, p_vs, p_sof, p_de & ~c_de, p_err});
        else
            chk("first_beat_silent", pixel_valid, 0);
        p_have = 1; p_pix = c_pix; p_de = c_de; p_hs = m_hs; p_vs = m_vs;
        p_sof = c_sof; p_err = c_err;
        while (gap_mode && ($urandom_range(0, 1) == 1)) begin
            @(posedge clk); #1;
            chk("gap_idle", pixel_valid, 0);
        end
    endtask

    task automatic send_frame(input int nlines, input int npix,
                              input int short_line, input int rst_line);
        logic       lvl;
        logic [7:0] bb;
        int         n;
        frame_vs = ~frame_vs;
        lvl = frame_vs;
        repeat (3) beat(c_T00, c_T00, tokv({lvl, 1'b0}));
        for (int l = 0; l < nlines; l++) begin
            repeat (2) beat(c_T00, c_T00, tokv({lvl, 1'b1}));
            beat(c_T00, c_T00, tokv({lvl, 1'b0}));
            n = (l == short_line) ? npix - 1 : npix;
            for (int p = 0; p < n; p++) begin
                if (l == rst_line && p == 3) do_reset();
                bb = 8'(l * 16 + p);
                beat({2'b00, bb ^ 8'hA5}, {2'b10, bb}, {2'b01, bb});
            end
        end
        beat(c_T00, c_T00, tokv({lvl, 1'b0}));
    endtask

    task automatic chk_timing(input string tag, input logic l,
                              input logic [11:0] h, input logic [11:0] v);
        chk(tag, {timing_locked, h_active, v_active}, {l, h, v});
    endtask

    initial begin
        logic [9:0] s0, s1, s2;
        rst = 1'b0; valid_in = 1'b0; data_in = 30'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // control token decode
        beat(c_T00, c_T00, c_T00);
        beat(10'h100, 10'h100, 10'h100);
        chk("tok_00", {hsync, vsync, de, sym_err, pixel}, 28'd0);
        beat(c_T10, c_T10, c_T10);
        beat(10'h100, 10'h100, 10'h100);
        chk("tok_10", {hsync, vsync, de, sym_err, pixel}, {2'b01, 26'd0});

        // data decode
        beat(10'h100, 10'h100, 10'h100);
        beat(10'h300, 10'h300, 10'h300);
        chk("dec_zero", {de, pixel}, {1'b1, 24'h000000});
        beat(c_T00, c_T00, c_T00);
        chk("dec_inv", {de, pixel}, {1'b1, 24'h010101});

        // random data symbols against the encoder-search reference
        for (int i = 0; i < 1024; i++) begin
            s0 = 10'($urandom_range(0, 1023)); if (tok_dec(s0)[2]) s0 = 10'h100;
            s1 = 10'($urandom_range(0, 1023)); if (tok_dec(s1)[2]) s1 = 10'h100;
            s2 = 10'($urandom_range(0, 1023)); if (tok_dec(s2)[2]) s2 = 10'h100;
            beat(s2, s1, s0);
        end

        // small frames, no gaps
        do_reset();
        send_frame(4, 8, -1, -1); chk_timing("frame1", 1'b0, 12'd0, 12'd0);
        send_frame(4, 8, -1, -1); chk_timing("frame2", 1'b0, 12'd8, 12'd4);
        send_frame(4, 8, -1, -1); chk_timing("frame3_lock", 1'b1, 12'd8, 12'd4);

        // same stream with random valid gaps
        do_reset();
        gap_mode = 1'b1; n_in = 0; pv0 = n_pv;
        send_frame(4, 8, -1, -1); chk_timing("gap_frame1", 1'b0, 12'd0, 12'd0);
        send_frame(4, 8, -1, -1); chk_timing("gap_frame2", 1'b0, 12'd8, 12'd4);
        send_frame(4, 8, -1, -1); chk_timing("gap_frame3_lock", 1'b1, 12'd8, 12'd4);
        gap_mode = 1'b0;
        @(negedge clk); #1;
        chk("pv_count", 64'(n_pv - pv0), 64'(n_in - 1));

        // instability: one short line, then relock
        send_frame(4, 8, 1, -1);  chk_timing("short_frame_sof", 1'b1, 12'd8, 12'd4);
        send_frame(4, 8, -1, -1); chk_timing("unlock", 1'b0, 12'd8, 12'd4);
        send_frame(4, 8, -1, -1); chk_timing("relock_1", 1'b0, 12'd8, 12'd4);
        send_frame(4, 8, -1, -1); chk_timing("relock_2", 1'b1, 12'd8, 12'd4);

        // channel disagreement
        beat(10'h105, c_T00, 10'h107);
        beat(c_T00, c_T00, tokv({m_vs, 1'b0}));
        chk("sym_err_hit", sym_err, 1);
        beat(c_T00, c_T00, tokv({m_vs, 1'b0}));
        chk("sym_err_clear", sym_err, 0);

        // reset in the middle of a line
        do_reset();
        send_frame(4, 8, -1, -1); chk_timing("pre_rst_frame", 1'b0, 12'd0, 12'd0);
        send_frame(4, 8, -1, 2);  chk_timing("rst_frame", 1'b0, 12'd0, 12'd0);
        send_frame(4, 8, -1, -1); chk_timing("post_rst_a", 1'b0, 12'd0, 12'd0);
        send_frame(4, 8, -1, -1); chk_timing("post_rst_b", 1'b0, 12'd8, 12'd4);
        send_frame(4, 8, -1, -1); chk_timing("post_rst_c", 1'b1, 12'd8, 12'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
